// File: rtl/audio_i2s_receiver_if.sv
// Parallel sample bus presented by the I2S capture block.
// master drives captured words and strobes, slave consumes them.
interface audio_i2s_receiver_if #(
    parameter int W = 24
);
    logic [W-1:0] o_lsound_in;
    logic [W-1:0] o_rsound_in;
    logic         o_sample_valid;
    logic         o_frame_err;

    modport master (
        output o_lsound_in,
        output o_rsound_in,
        output o_sample_valid,
        output o_frame_err
    );

    modport slave (
        input o_lsound_in,
        input o_rsound_in,
        input o_sample_valid,
        input o_frame_err
    );
endinterface

// File: rtl/audio_i2s_receiver.sv
// I2S ADC capture: oversamples BCLK/LRCK/DAT on iCLK and
// deserialises MSB-first words into left/right sample pairs.
module audio_i2s_receiver #(
    parameter int AUD_BIT_DEPTH = 24,
    parameter int SYNC_STAGES   = 2
) (
    input  logic iCLK,
    input  logic reset_reg,
    input  logic iAUD_BCLK,
    input  logic iAUD_ADCLRCK,
    input  logic iAUD_ADCDAT,
    audio_i2s_receiver_if.master aud
);
    localparam int CW = $clog2(AUD_BIT_DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(AUD_BIT_DEPTH);

    logic [SYNC_STAGES-1:0]   r_bclk_sync;
    logic [SYNC_STAGES-1:0]   r_lrck_sync;
    logic [SYNC_STAGES-1:0]   r_dat_sync;
    logic                     r_bclk_d;
    logic                     r_lrck_prev;
    logic                     r_primed;
    logic                     r_aligned;
    logic                     r_left_ok;
    logic [CW-1:0]            r_bit_cnt;
    logic [AUD_BIT_DEPTH-1:0] r_shift;
    logic [AUD_BIT_DEPTH-1:0] r_left;
    logic [AUD_BIT_DEPTH-1:0] r_lsound;
    logic [AUD_BIT_DEPTH-1:0] r_rsound;
    logic                     r_valid;
    logic                     r_err;

    logic w_s_bclk;
    logic w_s_lrck;
    logic w_s_dat;
    logic w_bclk_rise;
    logic w_full;

    assign w_s_bclk    = r_bclk_sync[SYNC_STAGES-1];
    assign w_s_lrck    = r_lrck_sync[SYNC_STAGES-1];
    assign w_s_dat     = r_dat_sync[SYNC_STAGES-1];
    assign w_bclk_rise = w_s_bclk & ~r_bclk_d;
    assign w_full      = (r_bit_cnt >= FULL);

    always_ff @(posedge iCLK) begin
        if (reset_reg) begin
            r_bclk_sync <= '0;
            r_lrck_sync <= '0;
            r_dat_sync  <= '0;
            r_bclk_d    <= 1'b0;
        end else begin
            r_bclk_sync <= {r_bclk_sync[SYNC_STAGES-2:0], iAUD_BCLK};
            r_lrck_sync <= {r_lrck_sync[SYNC_STAGES-2:0], iAUD_ADCLRCK};
            r_dat_sync  <= {r_dat_sync[SYNC_STAGES-2:0], iAUD_ADCDAT};
            r_bclk_d    <= w_s_bclk;
        end
    end

    // The first edge after reset only samples LRCK; the first
    // transition after that only aligns and never reports an error.
    always_ff @(posedge iCLK) begin
        if (reset_reg) begin
            r_lrck_prev <= 1'b0;
            r_primed    <= 1'b0;
            r_aligned   <= 1'b0;
            r_left_ok   <= 1'b0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_left      <= '0;
            r_lsound    <= '0;
            r_rsound    <= '0;
            r_valid     <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            if (w_bclk_rise) begin
                r_lrck_prev <= w_s_lrck;
                r_primed    <= 1'b1;
                if (!r_primed) begin
                    r_bit_cnt <= '0;
                end else if (w_s_lrck != r_lrck_prev) begin
                    r_bit_cnt <= '0;
                    if (!r_aligned) begin
                        r_aligned <= 1'b1;
                    end else if (w_full) begin
                        if (!r_lrck_prev) begin
                            r_left    <= r_shift;
                            r_left_ok <= 1'b1;
                        end else if (r_left_ok) begin
                            r_lsound  <= r_left;
                            r_rsound  <= r_shift;
                            r_valid   <= 1'b1;
                            r_left_ok <= 1'b0;
                        end
                    end else begin
                        r_err     <= 1'b1;
                        r_left_ok <= 1'b0;
                    end
                end else if (!w_full) begin
                    r_shift   <= {r_shift[AUD_BIT_DEPTH-2:0], w_s_dat};
                    r_bit_cnt <= r_bit_cnt + CW'(1);
                end
            end
        end
    end

    assign aud.o_lsound_in    = r_lsound;
    assign aud.o_rsound_in    = r_rsound;
    assign aud.o_sample_valid = r_valid;
    assign aud.o_frame_err    = r_err;
endmodule

// File: tb/tb_audio_i2s_receiver.sv
// Directed bench for audio_i2s_receiver: BCLK = iCLK/8,
// hand-built I2S frames with expected words written inline.
module tb_audio_i2s_receiver;
    logic iCLK = 1'b0;
    logic reset_reg = 1'b1;
    logic iAUD_BCLK = 1'b0;
    logic iAUD_ADCLRCK = 1'b1;
    logic iAUD_ADCDAT = 1'b0;
    logic cur_lr = 1'b1;

    int n_chk = 0;
    int n_err = 0;
    int n_valid = 0;
    int n_ferr = 0;
    int n_both = 0;
    int v0;
    int e0;

    audio_i2s_receiver_if #(.W(24)) aud ();

    audio_i2s_receiver #(
        .AUD_BIT_DEPTH(24),
        .SYNC_STAGES(2)
    ) dut (
        .iCLK(iCLK),
        .reset_reg(reset_reg),
        .iAUD_BCLK(iAUD_BCLK),
        .iAUD_ADCLRCK(iAUD_ADCLRCK),
        .iAUD_ADCDAT(iAUD_ADCDAT),
        .aud(aud.master)
    );

    always #5 iCLK = ~iCLK;

    always @(negedge iCLK) begin
        if (aud.o_sample_valid === 1'b1) n_valid++;
        if (aud.o_frame_err === 1'b1) n_ferr++;
        if (aud.o_sample_valid === 1'b1 && aud.o_frame_err === 1'b1)
            n_both++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge iCLK);
            #1;
        end
    endtask

    task automatic send_bit(input logic lr, input logic d);
        iAUD_ADCLRCK = lr;
        iAUD_ADCDAT  = d;
        tick(4);
        iAUD_BCLK = 1'b1;
        tick(4);
        iAUD_BCLK = 1'b0;
    endtask

    // Delay-slot bit whenever the channel changes.
    task automatic flip(input logic lr);
        if (cur_lr != lr) begin
            send_bit(lr, 1'b0);
            cur_lr = lr;
        end
    endtask

    task automatic half(input logic lr, input logic [23:0] w,
                        input int slot);
        flip(lr);
        for (int i = 0; i < slot; i++)
            send_bit(lr, (i < 24) ? w[23-i] : 1'b1);
    endtask

    task automatic pair_check(input string tag, input logic [23:0] l,
                              input logic [23:0] r, input int slot);
        v0 = n_valid;
        e0 = n_ferr;
        half(1'b0, l, slot);
        half(1'b1, r, slot);
        flip(1'b0);
        tick(4);
        chk({tag, "_valid"}, 32'(n_valid - v0), 32'd1);
        chk({tag, "_ferr"}, 32'(n_ferr - e0), 32'd0);
        chk({tag, "_l"}, 32'(aud.o_lsound_in), 32'(l));
        chk({tag, "_r"}, 32'(aud.o_rsound_in), 32'(r));
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            iAUD_BCLK = ~iAUD_BCLK;
            tick(1);
        end
        iAUD_BCLK = 1'b0;
        chk("rst_l", 32'(aud.o_lsound_in), 32'h0);
        chk("rst_r", 32'(aud.o_rsound_in), 32'h0);
        chk("rst_valid", 32'(aud.o_sample_valid), 32'h0);
        reset_reg = 1'b0;
        tick(2);

        // Start mid right half-frame
        for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b1);
        half(1'b0, 24'h123455, 32);
        chk("mid_no_valid", 32'(n_valid), 32'd0);
        chk("mid_no_ferr", 32'(n_ferr), 32'd0);
        half(1'b1, 24'hABCDEE, 32);
        flip(1'b0);
        tick(4);
        chk("mid_valid", 32'(n_valid), 32'd1);
        chk("mid_l", 32'(aud.o_lsound_in), 32'h123455);
        chk("mid_r", 32'(aud.o_rsound_in), 32'hABCDEE);

        pair_check("f0", 24'h123456, 24'hABCDEF, 32);
        pair_check("f1", 24'h123457, 24'hABCDF0, 32);
        pair_check("f2", 24'h123458, 24'hABCDF1, 32);
        pair_check("f3", 24'h123459, 24'hABCDF2, 32);

        pair_check("x24", 24'h800000, 24'h7FFFFF, 24);

        // 16-bit left slot
        v0 = n_valid;
        e0 = n_ferr;
        half(1'b0, 24'h111111, 16);
        half(1'b1, 24'h222222, 24);
        flip(1'b0);
        tick(4);
        chk("short_ferr", 32'(n_ferr - e0), 32'd1);
        chk("short_valid", 32'(n_valid - v0), 32'd0);
        chk("short_l", 32'(aud.o_lsound_in), 32'h800000);
        chk("short_r", 32'(aud.o_rsound_in), 32'h7FFFFF);
        pair_check("post_short", 24'h654321, 24'h0ABCDE, 32);

        // Reset on the 10th bit of a left word
        v0 = n_valid;
        e0 = n_ferr;
        for (int i = 0; i < 9; i++) send_bit(1'b0, 1'b1);
        iAUD_ADCDAT = 1'b1;
        tick(4);
        iAUD_BCLK = 1'b1;
        reset_reg = 1'b1;
        tick(1);
        reset_reg = 1'b0;
        tick(3);
        iAUD_BCLK = 1'b0;
        chk("rr_l0", 32'(aud.o_lsound_in), 32'h0);
        chk("rr_r0", 32'(aud.o_rsound_in), 32'h0);
        for (int i = 0; i < 14; i++) send_bit(1'b0, 1'b1);
        half(1'b1, 24'h555555, 32);
        flip(1'b0);
        tick(4);
        chk("rr_no_valid", 32'(n_valid - v0), 32'd0);
        chk("rr_no_ferr", 32'(n_ferr - e0), 32'd0);
        pair_check("rr_pair", 24'h0F0F0F, 24'hF0F0F0, 32);

        chk("valid_err_overlap", 32'(n_both), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
